// File: rtl/flappy_pkg.sv
// Shared constants and types for the flappy-bird LED game blocks.
// Holds the matrix geometry, the column bitmap type and the gap geometry
// defaults used by the scroller, collision checker and renderers.
package flappy_pkg;

  localparam int unsigned ROWS       = 16;  // matrix height, row 0 = top
  localparam int unsigned NUM_COLS   = 16;  // matrix width, col 0 = left
  localparam int unsigned GAP_OFFSET = 2;   // added to gap height; keeps row 0 solid
  localparam int unsigned MIN_GAP    = 3;   // gap length for size == 0

  // One matrix column, bit r = pixel in row r, 1 = pipe.
  typedef logic [ROWS-1:0] column_t;

endpackage

// File: rtl/pipe_column_gen.sv
// Combinational pipe column builder.
// Turns a (height, size) gap request into one column bitmap: the gap rows
// are 0 and every other row is 1. The gap is clipped at the bottom edge,
// and a gap starting below the matrix yields a solid column.
// Ports:
//   height  in  3     gap height from the gap generator
//   size    in  3     gap size; only size[1:0] affects the length
//   column  out ROWS  resulting column bitmap, 1 = pipe
module pipe_column_gen
  import flappy_pkg::*;
#(
  parameter int unsigned ROWS       = flappy_pkg::ROWS,
  parameter int unsigned GAP_OFFSET = flappy_pkg::GAP_OFFSET,
  parameter int unsigned MIN_GAP    = flappy_pkg::MIN_GAP
) (
  input  logic [2:0]      height,
  input  logic [2:0]      size,
  output logic [ROWS-1:0] column
);

  // 5-bit arithmetic: largest top+len stays below 32, so nothing wraps.
  logic [4:0] top;
  logic [4:0] len_raw;
  logic [4:0] len;
  logic [4:0] gap_end;
  logic       unused_size_msb;

  assign unused_size_msb = size[2];

  always_comb begin
    top     = 5'(height) + 5'(GAP_OFFSET);
    len_raw = 5'(MIN_GAP) + 5'(size[1:0]);
    len     = len_raw;
    if (top >= 5'(ROWS)) begin
      len = '0;
    end else if (top + len_raw > 5'(ROWS)) begin
      len = 5'(ROWS) - top;
    end
    gap_end = top + len;
    column  = '1;
    for (int unsigned r = 0; r < ROWS; r++) begin
      if ((5'(r) >= top) && (5'(r) < gap_end)) begin
        column[r] = 1'b0;
      end
    end
  end

endmodule

// File: rtl/pipe_scroller.sv
// Scrolling pipe field for the LED matrix.
// Every scroll step the field shifts one column left and a new column enters
// at the right edge; pipe columns carry a gap sampled from the gap generator.
// Ports:
//   clock        in   1              system clock
//   reset        in   1              synchronous, active-high
//   enable       in   1              game running; low freezes all state
//   height       in   3              gap height from the gap generator
//   size         in   3              gap size from the gap generator
//   pipe_map     out  ROWS*NUM_COLS  bit [c*ROWS+r] = pixel (r,c), 1 = pipe
//   bird_column  out  ROWS           column BIRD_COL of pipe_map
//   scroll_tick  out  1              pulse in the cycle a new map first shows
//   score_pulse  out  1              pulse when a pipe's last column leaves BIRD_COL
module pipe_scroller
  import flappy_pkg::*;
#(
  parameter int unsigned ROWS         = flappy_pkg::ROWS,
  parameter int unsigned NUM_COLS     = flappy_pkg::NUM_COLS,
  parameter int unsigned TICK_DIV     = 5000000,
  parameter int unsigned PIPE_SPACING = 8,
  parameter int unsigned PIPE_WIDTH   = 2,
  parameter int unsigned GAP_OFFSET   = flappy_pkg::GAP_OFFSET,
  parameter int unsigned MIN_GAP      = flappy_pkg::MIN_GAP,
  parameter int unsigned BIRD_COL     = 3
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     enable,
  input  logic [2:0]               height,
  input  logic [2:0]               size,
  output logic [ROWS*NUM_COLS-1:0] pipe_map,
  output logic [ROWS-1:0]          bird_column,
  output logic                     scroll_tick,
  output logic                     score_pulse
);

  localparam int unsigned TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int unsigned SW = (PIPE_SPACING > 1) ? $clog2(PIPE_SPACING) : 1;
  // Spawn count at which a pipe's first column enters.
  localparam int unsigned S  = PIPE_SPACING - PIPE_WIDTH;

  logic [TW-1:0]   tick_cnt;
  logic [SW-1:0]   spawn_cnt;
  logic [2:0]      lat_height;
  logic [2:0]      lat_size;
  logic [ROWS-1:0] cols [NUM_COLS];

  logic            step;
  logic            gap_sample;
  logic            in_pipe;
  logic [2:0]      gen_height;
  logic [2:0]      gen_size;
  logic [ROWS-1:0] gen_col;
  logic [ROWS-1:0] entry_col;

  assign step       = enable && (tick_cnt == TW'(TICK_DIV - 1));
  assign gap_sample = (spawn_cnt == SW'(S));
  assign in_pipe    = (spawn_cnt >= SW'(S));

  // The first column of a pipe uses the live inputs; the rest reuse the
  // latched copy so all columns of one pipe are identical.
  assign gen_height = gap_sample ? height : lat_height;
  assign gen_size   = gap_sample ? size   : lat_size;

  pipe_column_gen #(
    .ROWS       (ROWS),
    .GAP_OFFSET (GAP_OFFSET),
    .MIN_GAP    (MIN_GAP)
  ) u_column_gen (
    .height (gen_height),
    .size   (gen_size),
    .column (gen_col)
  );

  assign entry_col = in_pipe ? gen_col : '0;

  always_ff @(posedge clock) begin
    if (reset) begin
      tick_cnt    <= '0;
      spawn_cnt   <= '0;
      lat_height  <= '0;
      lat_size    <= '0;
      scroll_tick <= 1'b0;
      score_pulse <= 1'b0;
      for (int unsigned c = 0; c < NUM_COLS; c++) begin
        cols[c] <= '0;
      end
    end else if (step) begin
      tick_cnt    <= '0;
      spawn_cnt   <= (spawn_cnt == SW'(PIPE_SPACING - 1)) ? '0 : spawn_cnt + 1'b1;
      scroll_tick <= 1'b1;
      // Last pipe column leaves the bird column: bird column occupied now,
      // column sliding into it is empty.
      score_pulse <= (cols[BIRD_COL] != '0) && (cols[BIRD_COL+1] == '0);
      if (gap_sample) begin
        lat_height <= height;
        lat_size   <= size;
      end
      for (int unsigned c = 0; c < NUM_COLS - 1; c++) begin
        cols[c] <= cols[c+1];
      end
      cols[NUM_COLS-1] <= entry_col;
    end else begin
      if (enable) begin
        tick_cnt <= tick_cnt + 1'b1;
      end
      scroll_tick <= 1'b0;
      score_pulse <= 1'b0;
    end
  end

  always_comb begin
    pipe_map = '0;
    for (int unsigned c = 0; c < NUM_COLS; c++) begin
      pipe_map[c*ROWS +: ROWS] = cols[c];
    end
  end

  assign bird_column = cols[BIRD_COL];

endmodule
